channel_state_ring: RTL and testbench

- Time-multiplexed per-channel state store: the storage end of the before_enawrite/before_enaread protocol used by the pipelined per-turbine math blocks.
- A write pulse opens a burst window of N_CH consecutive cycles that captures one `SINGLE-wide word per channel (e.g. y of channel k).
- A later read pulse opens a burst window that replays the words in the same channel order, feeding the k[n-1] terms back into the pipeline.
- Sits between a block's output register and its delayed-feedback operand path, one instance per fed-back signal.

---
 rtl/channel_state_ring.sv | 147 ++++++++++++++
 tb/tb_channel_state_ring.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/channel_state_ring.sv
// Time-multiplexed per-channel state store: a delayed write burst captures N_CH words,
// a delayed read burst replays them in order. Optional CHANNEL_STATE_RING_PRIME_EN adds a primed flag.
module channel_state_ring #(
  parameter int WIDTH  = 32,
  parameter int N_CH   = 4,
  parameter int DEPTH  = 8,
  parameter int WR_DLY = 2,
  parameter int RD_DLY = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       rst_user,
  input  logic                       before_enawrite,
  input  logic                       before_enaread,
  input  logic [WIDTH-1:0]           cin,
  output logic [WIDTH-1:0]           cout,
  output logic [$clog2(DEPTH):0]     level,
  output logic                       full,
  output logic                       empty,
  output logic                       wr_busy,
  output logic                       rd_busy,
  output logic                       ovf_err,
  output logic                       udf_err
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam int CW = (N_CH > 1) ? $clog2(N_CH) : 1;

  logic [WIDTH-1:0]  r_mem [DEPTH];
  logic [AW-1:0]     r_wr_ptr, r_rd_ptr;
  logic [LW-1:0]     r_level;
  logic [WR_DLY-1:0] r_wr_dly;
  logic [RD_DLY-1:0] r_rd_dly;
  logic              r_wr_act, r_rd_act;
  logic [CW-1:0]     r_wr_cnt, r_rd_cnt;
  logic              r_ovf, r_udf;
  logic [WIDTH-1:0]  r_cout;

  logic w_clr, w_full, w_empty;
  logic w_wr_win, w_wr_last, w_wr_pend, w_wr_start, w_wr_acc;
  logic w_rd_win, w_rd_last, w_rd_pend, w_rd_start, w_rd_acc, w_rd_udf;
  logic [WIDTH-1:0] w_fill;

  assign w_clr   = rst | rst_user;
  assign w_full  = (r_level == LW'(DEPTH));
  assign w_empty = (r_level == '0);

  // A window is live on the cycle the delay line emits the pulse and while the counter runs.
  assign w_wr_win   = r_wr_dly[WR_DLY-1] | r_wr_act;
  assign w_wr_last  = w_wr_win & (r_wr_cnt == CW'(N_CH - 1));
  assign w_wr_pend  = (|r_wr_dly) | r_wr_act;
  assign w_wr_start = before_enawrite & ~w_wr_pend;
  assign w_wr_acc   = w_wr_win & ~w_full;

  assign w_rd_win   = r_rd_dly[RD_DLY-1] | r_rd_act;
  assign w_rd_last  = w_rd_win & (r_rd_cnt == CW'(N_CH - 1));
  assign w_rd_pend  = (|r_rd_dly) | r_rd_act;
  assign w_rd_start = before_enaread & ~w_rd_pend;

`ifdef CHANNEL_STATE_RING_PRIME_EN
  localparam logic [WIDTH-1:0] PRIME_VAL = '0;
  logic r_primed;

  // Until the first full write burst lands, reads replay PRIME_VAL and leave the store alone.
  assign w_rd_acc = w_rd_win & ~w_empty & r_primed;
  assign w_rd_udf = w_rd_win & w_empty & r_primed;
  assign w_fill   = r_primed ? '0 : PRIME_VAL;

  always_ff @(posedge clk) begin
    if (w_clr)          r_primed <= 1'b0;
    else if (w_wr_last) r_primed <= 1'b1;
  end
`else
  assign w_rd_acc = w_rd_win & ~w_empty;
  assign w_rd_udf = w_rd_win & w_empty;
  assign w_fill   = '0;
`endif

  // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk) begin
    if (w_clr) begin
      r_wr_dly <= '0;
      r_rd_dly <= '0;
      r_wr_act <= 1'b0;
      r_rd_act <= 1'b0;
      r_wr_cnt <= '0;
      r_rd_cnt <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
      r_ovf    <= 1'b0;
      r_udf    <= 1'b0;
    end else begin
      for (int i = WR_DLY - 1; i > 0; i--) r_wr_dly[i] <= r_wr_dly[i-1];
      r_wr_dly[0] <= w_wr_start;
      for (int i = RD_DLY - 1; i > 0; i--) r_rd_dly[i] <= r_rd_dly[i-1];
      r_rd_dly[0] <= w_rd_start;

      if (w_wr_win) begin
        r_wr_act <= ~w_wr_last;
        r_wr_cnt <= w_wr_last ? '0 : r_wr_cnt + 1'b1;
      end
      if (w_rd_win) begin
        r_rd_act <= ~w_rd_last;
        r_rd_cnt <= w_rd_last ? '0 : r_rd_cnt + 1'b1;
      end

      if (w_wr_acc) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_rd_acc) r_rd_ptr <= r_rd_ptr + 1'b1;

      case ({w_wr_acc, w_rd_acc})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: r_level <= r_level;
      endcase

      r_ovf <= r_ovf | (w_wr_win & w_full) | (before_enawrite & w_wr_pend);
      r_udf <= r_udf | w_rd_udf | (before_enaread & w_rd_pend);
    end
  end

  // NOTE: the storage array has no reset; level and pointers define which words are meaningful.
  always_ff @(posedge clk) begin
    if (!w_clr && w_wr_acc) r_mem[r_wr_ptr] <= cin;
  end

  // Reading the array here sees the pre-edge word, giving read-before-write on a shared address.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cout <= '0;
    end else if (!rst_user) begin
      if (w_rd_acc)      r_cout <= r_mem[r_rd_ptr];
      else if (w_rd_win) r_cout <= w_fill;
    end
  end

  assign cout    = r_cout;
  assign level   = r_level;
  assign full    = w_full;
  assign empty   = w_empty;
  assign wr_busy = w_wr_win;
  assign rd_busy = w_rd_win;
  assign ovf_err = r_ovf;
  assign udf_err = r_udf;

endmodule

// File: tb/tb_channel_state_ring.sv
// Bench for channel_state_ring: scenario tasks plus randomized traffic against a queue-based model.
module tb_channel_state_ring;

  localparam int WIDTH = 32, N_CH = 4, DEPTH = 8, WR_DLY = 2, RD_DLY = 1;
  localparam logic [31:0] BASE = 32'h3F80_0000;

  logic             clk = 1'b0;
  logic             rst = 1'b1, rst_user = 1'b0;
  logic             before_enawrite = 1'b0, before_enaread = 1'b0;
  logic [WIDTH-1:0] cin = '0;
  logic [WIDTH-1:0] cout;
  logic [3:0]       level;
  logic             full, empty, wr_busy, rd_busy, ovf_err, udf_err;

  int n_tests = 0;
  int n_fail  = 0;

  channel_state_ring #(.WIDTH(WIDTH), .N_CH(N_CH), .DEPTH(DEPTH), .WR_DLY(WR_DLY), .RD_DLY(RD_DLY)) dut (
    .clk(clk), .rst(rst), .rst_user(rst_user),
    .before_enawrite(before_enawrite), .before_enaread(before_enaread),
    .cin(cin), .cout(cout), .level(level), .full(full), .empty(empty),
    .wr_busy(wr_busy), .rd_busy(rd_busy), .ovf_err(ovf_err), .udf_err(udf_err)
  );

  always #5 clk = ~clk;

  // Reference model: a FIFO queue plus the absolute cycle at which each window opens.
  int               cyc = 0;
  int               m_wr_start = -1, m_rd_start = -1;
  logic [WIDTH-1:0] m_q[$];
  logic [WIDTH-1:0] m_cout = '0;
  bit               m_ovf = 0, m_udf = 0, m_primed = 0;

  function automatic bit in_win(int s, int c);
    return (s >= 0) && (c >= s) && (c < s + N_CH);
  endfunction

  task automatic model_step();
    bit wr_in, rd_in, rd_live;
    int sz;
    if (rst || rst_user) begin
      m_q.delete();
      m_wr_start = -1; m_rd_start = -1;
      m_ovf = 0; m_udf = 0; m_primed = 0;
      if (rst) m_cout = '0;
      return;
    end
    wr_in   = in_win(m_wr_start, cyc);
    rd_in   = in_win(m_rd_start, cyc);
    sz      = m_q.size();
    rd_live = 1'b1;
`ifdef CHANNEL_STATE_RING_PRIME_EN
    rd_live = m_primed;
`endif
    if (rd_in) begin
      if (!rd_live)    m_cout = '0;
      else if (sz > 0) m_cout = m_q.pop_front();
      else begin m_cout = '0; m_udf = 1; end
    end
    if (wr_in) begin
      if (sz < DEPTH) m_q.push_back(cin);
      else            m_ovf = 1;
      if (cyc == m_wr_start + N_CH - 1) m_primed = 1;
    end
    if (before_enawrite) begin
      if (m_wr_start >= 0 && cyc < m_wr_start + N_CH) m_ovf = 1;
      else m_wr_start = cyc + WR_DLY;
    end
    if (before_enaread) begin
      if (m_rd_start >= 0 && cyc < m_rd_start + N_CH) m_udf = 1;
      else m_rd_start = cyc + RD_DLY;
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic idle(int n);
    before_enawrite = 0; before_enaread = 0;
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic soft_clear();
    rst_user = 1; tick(); rst_user = 0;
  endtask

  task automatic write_burst(logic [31:0] base);
    for (int i = 0; i <= WR_DLY + N_CH; i++) begin
      before_enawrite = (i == 0);
      cin = base + 32'(i - WR_DLY);
      tick();
    end
    before_enawrite = 0;
  endtask

  task automatic test_reset();
    rst = 1; tick(); tick(); rst = 0;
    n_tests++; if (cout !== '0)      begin n_fail++; $display("FAIL reset_cout: got %h want 0", cout); end
    n_tests++; if (level !== 4'd0)   begin n_fail++; $display("FAIL reset_level: got %0d want 0", level); end
    n_tests++; if (empty !== 1'b1 || full !== 1'b0) begin n_fail++; $display("FAIL reset_flags: empty %b full %b want 1 0", empty, full); end
    n_tests++; if ({wr_busy, rd_busy, ovf_err, udf_err} !== 4'b0) begin n_fail++; $display("FAIL reset_busy_err: got %b want 0000", {wr_busy, rd_busy, ovf_err, udf_err}); end
  endtask

  task automatic test_basic_write();
    for (int i = 0; i < 8; i++) begin
      before_enawrite = (i == 0);
      cin = (i >= 2 && i <= 5) ? BASE + 32'(i - 2) : 32'hDEAD_0000 + 32'(i);
      n_tests++;
      if (wr_busy !== (i >= 2 && i <= 5)) begin n_fail++; $display("FAIL wr_busy_c%0d: got %b want %b", i, wr_busy, (i >= 2 && i <= 5)); end
      tick();
    end
    idle(2);
    n_tests++; if (level !== 4'd4) begin n_fail++; $display("FAIL write_level: got %0d want 4", level); end
    n_tests++; if (full !== 1'b0)  begin n_fail++; $display("FAIL write_full: got %b want 0", full); end
  endtask

  task automatic test_basic_read();
    for (int i = 0; i < 8; i++) begin
      before_enaread = (i == 0);
      if (i >= 2 && i <= 5) begin
        n_tests++;
        if (cout !== BASE + 32'(i - 2)) begin n_fail++; $display("FAIL read_cout_c%0d: got %h want %h", i, cout, BASE + 32'(i - 2)); end
      end
      tick();
    end
    n_tests++; if (level !== 4'd0) begin n_fail++; $display("FAIL read_level: got %0d want 0", level); end
    n_tests++; if (empty !== 1'b1 || udf_err !== 1'b0) begin n_fail++; $display("FAIL read_flags: empty %b udf %b want 1 0", empty, udf_err); end
  endtask

  task automatic test_overflow();
    soft_clear();
    write_burst(32'h1000);
    write_burst(32'h2000);
    n_tests++; if (level !== 4'd8 || full !== 1'b1 || ovf_err !== 1'b0) begin n_fail++; $display("FAIL ovf_two_bursts: level %0d full %b ovf %b want 8 1 0", level, full, ovf_err); end
    write_burst(32'h3000);
    n_tests++; if (level !== 4'd8 || ovf_err !== 1'b1) begin n_fail++; $display("FAIL ovf_third_burst: level %0d ovf %b want 8 1", level, ovf_err); end
    idle(5);
    n_tests++; if (ovf_err !== 1'b1) begin n_fail++; $display("FAIL ovf_sticky: got %b want 1", ovf_err); end
    soft_clear();
    n_tests++; if (ovf_err !== 1'b0 || level !== 4'd0) begin n_fail++; $display("FAIL ovf_clear: ovf %b level %0d want 0 0", ovf_err, level); end
  endtask

  task automatic test_underflow();
    bit exp_udf;
    n_tests++; if (cout !== BASE + 32'd3) begin n_fail++; $display("FAIL udf_cout_held: got %h want %h", cout, BASE + 32'd3); end
    for (int i = 0; i < 8; i++) begin
      before_enaread = (i == 0);
      if (i >= 2 && i <= 5) begin
        n_tests++;
        if (cout !== '0) begin n_fail++; $display("FAIL udf_cout_c%0d: got %h want 0", i, cout); end
      end
      tick();
    end
`ifdef CHANNEL_STATE_RING_PRIME_EN
    exp_udf = 0;
`else
    exp_udf = 1;
`endif
    n_tests++; if (udf_err !== exp_udf) begin n_fail++; $display("FAIL udf_flag: got %b want %b", udf_err, exp_udf); end
    soft_clear();
  endtask

  task automatic test_collision();
    soft_clear();
    before_enawrite = 1; cin = 32'h55; tick();
    before_enawrite = 1; tick();
    before_enawrite = 0;
    idle(6);
    n_tests++; if (ovf_err !== 1'b1 || level !== 4'd4) begin n_fail++; $display("FAIL collision: ovf %b level %0d want 1 4", ovf_err, level); end
    soft_clear();
  endtask

  task automatic test_overlap();
    logic [31:0] exp_base;
    write_burst(32'h100);
    for (int it = 0; it < 5; it++) begin
      exp_base = (it == 0) ? 32'h100 : 32'h200 + 32'((it - 1) * 16);
      for (int i = 0; i < 7; i++) begin
        before_enawrite = (i == 0);
        before_enaread  = (i == WR_DLY - RD_DLY);
        cin = 32'h200 + 32'(it * 16) + 32'(i - WR_DLY);
        tick();
        n_tests++;
        if (level !== 4'd4) begin n_fail++; $display("FAIL overlap_level_it%0d_c%0d: got %0d want 4", it, i, level); end
        if (i >= 2 && i < 2 + N_CH) begin
          n_tests++;
          if (cout !== exp_base + 32'(i - 2)) begin n_fail++; $display("FAIL overlap_cout_it%0d_c%0d: got %h want %h", it, i, cout, exp_base + 32'(i - 2)); end
        end
      end
    end
    before_enawrite = 0; before_enaread = 0;
  endtask

  task automatic test_rst_user_mid();
    logic [WIDTH-1:0] held;
    soft_clear();
    held = cout;
    for (int i = 0; i < 4; i++) begin
      before_enawrite = (i == 0);
      rst_user = (i == 3);
      cin = 32'hABC0 + 32'(i);
      tick();
    end
    rst_user = 0;
    n_tests++; if (wr_busy !== 1'b0 || level !== 4'd0) begin n_fail++; $display("FAIL rstu_mid: busy %b level %0d want 0 0", wr_busy, level); end
    n_tests++; if (cout !== held) begin n_fail++; $display("FAIL rstu_cout: got %h want %h", cout, held); end
    idle(4);
    n_tests++; if (level !== 4'd0 || wr_busy !== 1'b0) begin n_fail++; $display("FAIL rstu_aborted: level %0d busy %b want 0 0", level, wr_busy); end
  endtask

  task automatic test_random();
    for (int n = 0; n < 600; n++) begin
      before_enawrite = ($urandom_range(0, 4) == 0);
      before_enaread  = ($urandom_range(0, 4) == 0);
      rst_user        = ($urandom_range(0, 149) == 0);
      cin             = $urandom;
      tick();
      n_tests++; if (cout !== m_cout) begin n_fail++; $display("FAIL rnd_cout@%0d: got %h want %h", cyc, cout, m_cout); end
      n_tests++; if (level !== 4'(m_q.size())) begin n_fail++; $display("FAIL rnd_level@%0d: got %0d want %0d", cyc, level, m_q.size()); end
      n_tests++; if (full !== (m_q.size() == DEPTH) || empty !== (m_q.size() == 0)) begin n_fail++; $display("FAIL rnd_flags@%0d: full %b empty %b size %0d", cyc, full, empty, m_q.size()); end
      n_tests++; if (wr_busy !== in_win(m_wr_start, cyc) || rd_busy !== in_win(m_rd_start, cyc)) begin n_fail++; $display("FAIL rnd_busy@%0d: got %b%b want %b%b", cyc, wr_busy, rd_busy, in_win(m_wr_start, cyc), in_win(m_rd_start, cyc)); end
      n_tests++; if (ovf_err !== m_ovf || udf_err !== m_udf) begin n_fail++; $display("FAIL rnd_err@%0d: got %b%b want %b%b", cyc, ovf_err, udf_err, m_ovf, m_udf); end
    end
    before_enawrite = 0; before_enaread = 0; rst_user = 0;
  endtask

  initial begin
    test_reset();
    idle(3);
    test_basic_write();
    test_basic_read();
    test_overflow();
    test_underflow();
    test_collision();
    test_overlap();
    test_rst_user_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
